// File: rtl/dcache_ctrl.sv
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped, write-back, write-allocate data cache for the
//               MEM stage. It stalls the pipeline on a miss while it writes
//               back the victim line and refills the requested one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_ctrl #(
  parameter int LINES     = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_wdata_i,
  input  logic                 cpu_memrd_i,
  input  logic                 cpu_memwr_i,
  output logic [31:0]          cpu_rdata_o,
  output logic                 cpu_stall_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [LINE_BITS-1:0] mem_rdata_i,
  input  logic                 mem_ack_i
);

  localparam int c_IDX_W = $clog2(LINES);
  localparam int c_TAG_W = 32 - c_IDX_W - 5;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t               r_state;
  logic [LINES-1:0]     r_valid;
  logic [LINES-1:0]     r_dirty;
  logic [c_TAG_W-1:0]   r_tag  [LINES];
  logic [LINE_BITS-1:0] r_data [LINES];

  logic                 r_mem_enable;
  logic                 r_mem_write;
  logic [31:0]          r_mem_addr;
  logic [LINE_BITS-1:0] r_mem_wdata;

  logic [c_IDX_W-1:0]   w_idx;
  logic [c_TAG_W-1:0]   w_tag;
  logic [2:0]           w_off;
  logic                 w_req;
  logic                 w_hit;
  logic                 w_ack;
  logic [LINE_BITS-1:0] w_line;
  logic [31:0]          w_word;
  logic                 w_unused_addr;

  assign w_idx  = cpu_addr_i[c_IDX_W+4:5];
  assign w_tag  = cpu_addr_i[31:c_IDX_W+5];
  assign w_off  = cpu_addr_i[4:2];
  assign w_req  = cpu_memrd_i | cpu_memwr_i;
  assign w_hit  = w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_line = r_data[w_idx];
  assign w_word = w_line[32*w_off +: 32];
  // Acks that arrive while no request is outstanding are dropped.
  assign w_ack  = mem_ack_i & r_mem_enable;
  assign w_unused_addr = ^cpu_addr_i[1:0];

  assign cpu_rdata_o  = w_hit ? w_word : 32'd0;
  assign cpu_stall_o  = (r_state != S_IDLE) | (w_req & ~w_hit);
  assign mem_enable_o = r_mem_enable;
  assign mem_write_o  = r_mem_write;
  assign mem_addr_o   = r_mem_addr;
  assign mem_wdata_o  = r_mem_wdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && !w_hit) begin
            r_mem_enable <= 1'b1;
            if (r_valid[w_idx] && r_dirty[w_idx]) begin
              r_state     <= S_WRITEBACK;
              r_mem_write <= 1'b1;
              r_mem_addr  <= {r_tag[w_idx], w_idx, 5'b0};
              r_mem_wdata <= w_line;
            end else begin
              r_state     <= S_ALLOCATE;
              r_mem_write <= 1'b0;
              r_mem_addr  <= {w_tag, w_idx, 5'b0};
              r_mem_wdata <= '0;
            end
          end else if (w_hit && cpu_memwr_i) begin
            r_dirty[w_idx] <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          // Refill request follows the write-back ack with no idle gap.
          if (w_ack) begin
            r_state     <= S_ALLOCATE;
            r_mem_write <= 1'b0;
            r_mem_addr  <= {w_tag, w_idx, 5'b0};
            r_mem_wdata <= '0;
          end
        end
        S_ALLOCATE: begin
          if (w_ack) begin
            r_state        <= S_IDLE;
            r_mem_enable   <= 1'b0;
            r_mem_addr     <= '0;
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_mem_enable <= 1'b0;
          r_mem_write  <= 1'b0;
          r_mem_addr   <= '0;
          r_mem_wdata  <= '0;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; validity is tracked separately.
  always_ff @(posedge clk_i) begin
    if (r_state == S_ALLOCATE && w_ack) begin
      r_data[w_idx] <= mem_rdata_i;
      r_tag[w_idx]  <= w_tag;
    end else if (r_state == S_IDLE && w_hit && cpu_memwr_i) begin
      r_data[w_idx][32*w_off +: 32] <= cpu_wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Scoreboard bench for dcache_ctrl with a fixed-latency memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_ctrl;

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] wdata;
  } mem_exp_t;

  logic         clk;
  logic         rst;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_memrd;
  logic         cpu_memwr;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic         mem_enable;
  logic         mem_write;
  logic [255:0] mem_rdata;
  logic         mem_ack;

  logic [255:0] mem [128];
  logic         force_ack;
  int           ack_cnt;
  int           total;
  int           bad;
  logic [31:0]  exp_rd [$];
  mem_exp_t     exp_mem [$];

  dcache_ctrl #(.LINES(32), .LINE_BITS(256)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_memrd_i (cpu_memrd),
    .cpu_memwr_i (cpu_memwr),
    .cpu_rdata_o (cpu_rdata),
    .cpu_stall_o (cpu_stall),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_enable_o(mem_enable),
    .mem_write_o (mem_write),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = base + k;
    return l;
  endfunction

  // Memory model: acks on the 10th enabled cycle, back-to-back capable.
  initial begin
    ack_cnt   = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ack_cnt = 0;
        mem_ack = 1'b0;
      end else if (force_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = '1;
      end else if (!mem_enable) begin
        ack_cnt = 0;
        mem_ack = 1'b0;
      end else begin
        if (mem_ack) ack_cnt = 0;
        ack_cnt++;
        mem_ack = (ack_cnt == 10);
        if (mem_ack && mem_write)  mem[mem_addr[11:5]] = mem_wdata;
        if (mem_ack && !mem_write) mem_rdata = mem[mem_addr[11:5]];
      end
    end
  end

  // Monitor: pops the scoreboard whenever a load completes or memory acks.
  initial begin
    mem_exp_t m;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && cpu_memrd && !cpu_memwr && !cpu_stall) begin
        if (exp_rd.size() == 0) begin
          total++; bad++;
          $display("FAIL load_unexpected: got=%h want=none", cpu_rdata);
        end else begin
          e = exp_rd.pop_front();
          chk("load_data", {224'd0, cpu_rdata}, {224'd0, e});
        end
      end
      if (mem_enable && mem_ack) begin
        if (exp_mem.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_unexpected: got=%h want=none", mem_addr);
        end else begin
          m = exp_mem.pop_front();
          chk("mem_addr", {224'd0, mem_addr}, {224'd0, m.addr});
          chk("mem_write", {255'd0, mem_write}, {255'd0, m.wr});
          if (m.wr) chk("mem_wdata", mem_wdata, m.wdata);
        end
      end
    end
  end

  task automatic push_mem(input logic [31:0] a, input logic w, input logic [255:0] d);
    mem_exp_t m;
    m.addr = a; m.wr = w; m.wdata = d;
    exp_mem.push_back(m);
  endtask

  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d, input int exp_stall);
    int n;
    @(negedge clk);
    cpu_addr = a; cpu_wdata = d; cpu_memrd = rd; cpu_memwr = wr;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!cpu_stall) break;
      n++;
      @(negedge clk);
    end
    chk(name, n, exp_stall);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    cpu_memrd = 1'b0; cpu_memwr = 1'b0;
    #1;
    chk("idle_enable", {255'd0, mem_enable}, 256'd0);
    chk("idle_stall", {255'd0, cpu_stall}, 256'd0);
  endtask

  task automatic reset_mid_alloc();
    int n;
    @(negedge clk);
    cpu_addr = 32'h44; cpu_memrd = 1'b1; cpu_memwr = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && n < 5; i++) begin
      #1;
      if (mem_enable) n++;
      if (n < 5) @(negedge clk);
    end
    chk("alloc_addr", {224'd0, mem_addr}, 256'h40);
    chk("alloc_write", {255'd0, mem_write}, 256'd0);
    rst = 1'b1; cpu_memrd = 1'b0;
    #1;
    chk("rst_enable_drop", {255'd0, mem_enable}, 256'd0);
    chk("rst_addr", {224'd0, mem_addr}, 256'd0);
    chk("rst_stall", {255'd0, cpu_stall}, 256'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #3 force_ack = 1'b1;
    @(negedge clk);
    #3 force_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0; force_ack = 1'b0;
    rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_memrd = 1'b0; cpu_memwr = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[2]  = mk_line(32'h100);
    mem[34] = mk_line(32'h200);
    mem[68] = mk_line(32'h300);
    #1;
    chk("rst_mem_enable", {255'd0, mem_enable}, 256'd0);
    chk("rst_mem_write", {255'd0, mem_write}, 256'd0);
    chk("rst_mem_addr", {224'd0, mem_addr}, 256'd0);
    chk("rst_mem_wdata", mem_wdata, 256'd0);
    chk("rst_rdata", {224'd0, cpu_rdata}, 256'd0);
    chk("rst_stall0", {255'd0, cpu_stall}, 256'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    push_mem(32'h40, 1'b0, '0);
    exp_rd.push_back(32'h100);
    access("stall_clean_miss", 1'b1, 1'b0, 32'h40, 32'h0, 11);

    exp_rd.push_back(32'h101);
    access("stall_hit_load", 1'b1, 1'b0, 32'h44, 32'h0, 0);
    chk("hit_no_enable", {255'd0, mem_enable}, 256'd0);

    access("stall_hit_store", 1'b0, 1'b1, 32'h48, 32'hDEADBEEF, 0);
    exp_rd.push_back(32'hDEADBEEF);
    access("stall_load_after_store", 1'b1, 1'b0, 32'h48, 32'h0, 0);

    push_mem(32'h40, 1'b1, {32'h107, 32'h106, 32'h105, 32'h104,
                            32'h103, 32'hDEADBEEF, 32'h101, 32'h100});
    push_mem(32'h440, 1'b0, '0);
    exp_rd.push_back(32'h200);
    access("stall_dirty_miss", 1'b1, 1'b0, 32'h440, 32'h0, 21);

    push_mem(32'h880, 1'b0, '0);
    access("stall_store_miss", 1'b0, 1'b1, 32'h880, 32'h12345678, 11);
    exp_rd.push_back(32'h12345678);
    access("stall_load_merged", 1'b1, 1'b0, 32'h880, 32'h0, 0);
    idle_cycle();

    reset_mid_alloc();
    push_mem(32'h40, 1'b0, '0);
    exp_rd.push_back(32'h101);
    access("stall_after_reset", 1'b1, 1'b0, 32'h44, 32'h0, 11);
    idle_cycle();
    repeat (3) @(negedge clk);

    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("mem_queue_empty", exp_mem.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
